// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
//
// Purpose:
//   EX-stage execution unit for MULT/MULTU/DIV/DIVU and MTHI/MTLO.
//   Multiplies take MULT_CYCLES busy cycles and divides take DIV_CYCLES.
//   HI/LO change only on the completion edge or on an MTHI/MTLO write.
//   While an operation is in flight, stall_req holds back any decode-stage
//   instruction that touches HI/LO or the unit.
//
// Configuration:
//   MULDIV_DIV_EN - when defined, DIV/DIVU are supported. When undefined,
//                   the divider and the DIV state are absent, and mulop 3/4
//                   behave as no-ops.
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   start      in   1  mult/div strobe for the instruction in EX
//   mulop      in   4  1=MULT 2=MULTU 3=DIV 4=DIVU, others no-op
//   rs_val     in  32  rs operand / MTHI-MTLO data
//   rt_val     in  32  rt operand
//   whi        in   1  MTHI strobe
//   wlo        in   1  MTLO strobe
//   hazmulti   in   1  decode-stage instruction depends on HI/LO or the unit
//   cancel     in   1  exception flush
//   hi         out 32  HI register
//   lo         out 32  LO register
//   busy       out  1  operation in flight
//   stall_req  out  1  hazmulti & busy (combinational)

module muldiv_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  mulop,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        whi,
    input  logic        wlo,
    input  logic        hazmulti,
    input  logic        cancel,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_req
);

    // The counter is sized for the longer of the two latencies.
    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
`ifdef MULDIV_DIV_EN
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
`endif

`ifdef MULDIV_DIV_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               sgn_q, sgn_d;     // signed variant (MULT / DIV)
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               is_mul;
    logic [63:0]        a_ext;
    logic [63:0]        b_ext;
    logic [63:0]        prod;

    assign is_mul = (mulop == 4'd1) || (mulop == 4'd2);

    // A 64-bit product of the sign- or zero-extended operands gives the
    // correct low 64 bits for both signed and unsigned multiplication.
    always_comb begin
        a_ext = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        b_ext = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = a_ext * b_ext;
    end

`ifdef MULDIV_DIV_EN
    logic        is_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign is_div = (mulop == 4'd3) || (mulop == 4'd4);

    // Divide the magnitudes, then restore the signs. The quotient is negative
    // when the operand signs differ; the remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally: the magnitude quotient 0x80000000
    // keeps its bit pattern, and the remainder is 0.
    always_comb begin
        a_neg = sgn_q & a_q[31];
        b_neg = sgn_q & b_q[31];
        a_mag = a_neg ? (32'd0 - a_q) : a_q;
        b_mag = b_neg ? (32'd0 - b_q) : b_q;
        q_mag = 32'd0;
        r_mag = a_mag;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem = a_neg ? (32'd0 - r_mag) : r_mag;
        if (b_q == 32'd0) begin
            quo = 32'hFFFF_FFFF;
            rem = a_q;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                // cancel blocks every request in IDLE
                if (!cancel) begin
                    if (start && is_mul) begin
                        state_d = S_MUL;
                        cnt_d   = MUL_LOAD;
                        a_d     = rs_val;
                        b_d     = rt_val;
                        sgn_d   = (mulop == 4'd1);
`ifdef MULDIV_DIV_EN
                    end else if (start && is_div) begin
                        state_d = S_DIV;
                        cnt_d   = DIV_LOAD;
                        a_d     = rs_val;
                        b_d     = rt_val;
                        sgn_d   = (mulop == 4'd3);
`endif
                    end else begin
                        // A start with a no-op mulop leaves MTHI/MTLO free to proceed.
                        if (whi) begin
                            hi_d = rs_val;
                        end
                        if (wlo) begin
                            lo_d = rs_val;
                        end
                    end
                end
            end

            S_MUL: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

`ifdef MULDIV_DIV_EN
            S_DIV: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    hi_d    = rem;
                    lo_d    = quo;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = (state_q != S_IDLE);
    assign stall_req = hazmulti & busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit

module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  mulop;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        whi;
    logic        wlo;
    logic        hazmulti;
    logic        cancel;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_req;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mulop     (mulop),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .whi       (whi),
        .wlo       (wlo),
        .hazmulti  (hazmulti),
        .cancel    (cancel),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one start at the current negedge and then counts busy cycles
    // (bounded). hm/lm are HI/LO as seen in the first cycle after acceptance.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n, output logic [31:0] hm, output logic [31:0] lm);
        start  = 1'b1;
        mulop  = op;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mulop = 4'd0;
        hm = hi;
        lm = lo;
        n  = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic write_hilo(input logic w_hi, input logic w_lo, input logic [31:0] v);
        whi    = w_hi;
        wlo    = w_lo;
        rs_val = v;
        @(posedge clk);
        @(negedge clk);
        whi = 1'b0;
        wlo = 1'b0;
    endtask

    task automatic test_reset;
        hazmulti = 1'b1;
        #1;
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected %h", hi, 32'd0); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected %h", lo, 32'd0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
        hazmulti = 1'b0;
    endtask

    task automatic test_mult;
        int n;
        logic [31:0] hm, lm;
        run_op(4'd1, 32'hFFFF_FFFE, 32'h0000_0003, n, hm, lm);
        checks++; if (n !== 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 5", n); end
        checks++; if (hm !== 32'd0 || lm !== 32'd0) begin errors++; $display("FAIL mult_hilo_early: got %h/%h expected 0/0", hm, lm); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected FFFFFFFF", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h expected FFFFFFFA", lo); end

        run_op(4'd2, 32'hFFFF_FFFE, 32'h0000_0003, n, hm, lm);
        checks++; if (n !== 5) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 5", n); end
        checks++; if (hm !== 32'hFFFF_FFFF || lm !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_hilo_early: got %h/%h expected FFFFFFFF/FFFFFFFA", hm, lm); end
        checks++; if (hi !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi: got %h expected 00000002", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo: got %h expected FFFFFFFA", lo); end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div;
        int n;
        logic [31:0] hm, lm;
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, n, hm, lm);
        checks++; if (n !== 10) begin errors++; $display("FAIL div_busy_cycles: got %0d expected 10", n); end
        checks++; if (hm !== 32'h0000_0002 || lm !== 32'hFFFF_FFFA) begin errors++; $display("FAIL div_hilo_early: got %h/%h expected 00000002/FFFFFFFA", hm, lm); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h expected FFFFFFFD", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h expected FFFFFFFF", hi); end

        run_op(4'd3, 32'd7, 32'hFFFF_FFFE, n, hm, lm);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negdivisor_lo: got %h expected FFFFFFFD", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL div_negdivisor_hi: got %h expected 00000001", hi); end

        run_op(4'd4, 32'd7, 32'd0, n, hm, lm);
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_lo: got %h expected FFFFFFFF", lo); end
        checks++; if (hi !== 32'd7) begin errors++; $display("FAIL divu_zero_hi: got %h expected 00000007", hi); end

        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n, hm, lm);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi); end

        run_op(4'd4, 32'hFFFF_FFF9, 32'd2, n, hm, lm);
        checks++; if (lo !== 32'h7FFF_FFFC || hi !== 32'd1) begin errors++; $display("FAIL divu_big: got %h/%h expected 00000001/7FFFFFFC", hi, lo); end
    endtask
`else
    task automatic test_div_disabled;
        int n;
        logic [31:0] hm, lm;
        write_hilo(1'b1, 1'b0, 32'h0000_00AA);
        write_hilo(1'b0, 1'b1, 32'h0000_00BB);
        run_op(4'd3, 32'd10, 32'd3, n, hm, lm);
        checks++; if (n !== 0) begin errors++; $display("FAIL nodiv_busy: got %0d busy cycles expected 0", n); end
        checks++; if (hi !== 32'hAA || lo !== 32'hBB) begin errors++; $display("FAIL nodiv_hilo: got %h/%h expected 000000AA/000000BB", hi, lo); end
        run_op(4'd4, 32'd10, 32'd3, n, hm, lm);
        @(negedge clk);
        checks++; if (n !== 0 || busy !== 1'b0) begin errors++; $display("FAIL nodivu_busy: got %0d/%b expected 0/0", n, busy); end
        checks++; if (hi !== 32'hAA || lo !== 32'hBB) begin errors++; $display("FAIL nodivu_hilo: got %h/%h expected 000000AA/000000BB", hi, lo); end
    endtask
`endif

    task automatic test_stall;
        int n;
        int stalls;
        start  = 1'b1;
        mulop  = 4'd1;
        rs_val = 32'd3;
        rt_val = 32'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mulop = 4'd0;
        #1;
        checks++; if (busy !== 1'b1 || stall_req !== 1'b0) begin errors++; $display("FAIL stall_first: got busy=%b stall=%b expected 1/0", busy, stall_req); end
        hazmulti = 1'b1;
        #1;
        n = 1;
        stalls = 0;
        while (busy === 1'b1 && n < 60) begin
            if (stall_req === 1'b1) stalls++;
            @(negedge clk);
            #1;
            n++;
        end
        checks++; if (stalls !== 5) begin errors++; $display("FAIL stall_cycles: got %0d expected 5", stalls); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL stall_release: got %b expected 0", stall_req); end
        checks++; if (lo !== 32'd12 || hi !== 32'd0) begin errors++; $display("FAIL stall_result: got %h/%h expected 00000000/0000000C", hi, lo); end
        hazmulti = 1'b0;
    endtask

    task automatic test_mthi_mtlo;
        int n;
        logic [31:0] hm, lm;
        write_hilo(1'b1, 1'b0, 32'h1234_5678);
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi: got %h expected 12345678", hi); end
        write_hilo(1'b0, 1'b1, 32'h9ABC_DEF0);
        checks++; if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo: got %h/%h expected 12345678/9ABCDEF0", hi, lo); end
        write_hilo(1'b1, 1'b1, 32'h0F0F_0F0F);
        checks++; if (hi !== 32'h0F0F_0F0F || lo !== 32'h0F0F_0F0F) begin errors++; $display("FAIL mthi_mtlo_both: got %h/%h expected 0F0F0F0F/0F0F0F0F", hi, lo); end

        cancel = 1'b1;
        write_hilo(1'b1, 1'b1, 32'h1111_1111);
        cancel = 1'b0;
        checks++; if (hi !== 32'h0F0F_0F0F || lo !== 32'h0F0F_0F0F) begin errors++; $display("FAIL cancel_blocks_mt: got %h/%h expected 0F0F0F0F/0F0F0F0F", hi, lo); end

        // start and MTHI/MTLO in the same cycle: the writes are dropped
        whi = 1'b1;
        wlo = 1'b1;
        run_op(4'd2, 32'd5, 32'd7, n, hm, lm);
        whi = 1'b0;
        wlo = 1'b0;
        checks++; if (hm !== 32'h0F0F_0F0F || lm !== 32'h0F0F_0F0F) begin errors++; $display("FAIL start_blocks_mt: got %h/%h expected 0F0F0F0F/0F0F0F0F", hm, lm); end
        checks++; if (hi !== 32'd0 || lo !== 32'd35) begin errors++; $display("FAIL start_mt_result: got %h/%h expected 00000000/00000023", hi, lo); end

        // MTHI while busy is ignored
        start  = 1'b1;
        mulop  = 4'd1;
        rs_val = 32'd2;
        rt_val = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        whi    = 1'b1;
        rs_val = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        whi = 1'b0;
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL whi_busy_mid: got %h expected 00000000", hi); end
        n = 0;
        while (busy === 1'b1 && n < 60) begin n++; @(negedge clk); end
        checks++; if (hi !== 32'd0 || lo !== 32'd6) begin errors++; $display("FAIL whi_busy_result: got %h/%h expected 00000000/00000006", hi, lo); end
    endtask

    task automatic test_cancel;
        write_hilo(1'b1, 1'b1, 32'h0000_0055);
        start  = 1'b1;
`ifdef MULDIV_DIV_EN
        mulop  = 4'd4;
`else
        mulop  = 4'd2;
`endif
        rs_val = 32'd100;
        rt_val = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mulop = 4'd0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cancel_pre_busy: got %b expected 1", busy); end
        cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'h55 || lo !== 32'h55) begin errors++; $display("FAIL cancel_hilo: got %h/%h expected 00000055/00000055", hi, lo); end
        repeat (12) @(negedge clk);
        checks++; if (busy !== 1'b0 || hi !== 32'h55 || lo !== 32'h55) begin errors++; $display("FAIL cancel_later: got %b %h/%h expected 0 00000055/00000055", busy, hi, lo); end
    endtask

    task automatic test_reset_mid;
        start  = 1'b1;
        mulop  = 4'd1;
        rs_val = 32'd3;
        rt_val = 32'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mulop = 4'd0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rstmid_hilo: got %h/%h expected 0/0", hi, lo); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rstmid_after: got %b %h/%h expected 0 0/0", busy, hi, lo); end
    endtask

    task automatic test_back_to_back;
        int n;
        logic [31:0] hm, lm;
        run_op(4'd1, 32'd6, 32'd7, n, hm, lm);
        checks++; if (lo !== 32'd42 || hi !== 32'd0) begin errors++; $display("FAIL b2b_first: got %h/%h expected 00000000/0000002A", hi, lo); end
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, hm, lm);
        checks++; if (n !== 5) begin errors++; $display("FAIL b2b_second_cycles: got %0d expected 5", n); end
        checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'd1) begin errors++; $display("FAIL b2b_multu: got %h/%h expected FFFFFFFE/00000001", hi, lo); end
        run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, hm, lm);
        checks++; if (hi !== 32'd0 || lo !== 32'd1) begin errors++; $display("FAIL b2b_mult: got %h/%h expected 00000000/00000001", hi, lo); end
        run_op(4'd0, 32'd9, 32'd9, n, hm, lm);
        checks++; if (n !== 0 || hi !== 32'd0 || lo !== 32'd1) begin errors++; $display("FAIL noop0: got %0d %h/%h expected 0 00000000/00000001", n, hi, lo); end
        run_op(4'd5, 32'd9, 32'd9, n, hm, lm);
        checks++; if (n !== 0 || hi !== 32'd0 || lo !== 32'd1) begin errors++; $display("FAIL noop5: got %0d %h/%h expected 0 00000000/00000001", n, hi, lo); end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        mulop    = 4'd0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        whi      = 1'b0;
        wlo      = 1'b0;
        hazmulti = 1'b0;
        cancel   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_mult();
`ifdef MULDIV_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_stall();
        test_mthi_mtlo();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
